wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Write-back arbiter sharing the dual-write-port register file (16 × 32-bit, primary and `_c` write ports) among N_REQ functional-unit result sources. Each cycle it grants up to two pending results with round-robin fairness and maps them onto the primary and secondary write ports. It guarantees the two ports never target the same register in one cycle. Outputs are registered and drive the register file write inputs directly.

## Interface
- N_REQ, 3, number of requesters; legal range 2..4
- ADDR_W, 4, register address width
- DATA_W, 32, write data width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- hold  input  1  when 1, no grants this cycle
- req_valid  input  N_REQ  requester i has a result
- req_rd  input  N_REQ*ADDR_W  destination of requester i, slice [i*ADDR_W +: ADDR_W]
- req_data  input  N_REQ*DATA_W  result of requester i, slice [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  combinational grant; transfer when valid && ready
- regWrite, rd, writeData  output  1, ADDR_W, DATA_W  primary write port, registered
- regWrite_c, rd_c, writeData_c  output  1, ADDR_W, DATA_W  secondary write port, registered
- conflict_cnt  output  16  saturating count of same-destination blocking cycles

## Operation
- State: rr_ptr (0..N_REQ-1), six output registers, conflict_cnt.
- Scan order each cycle: rr_ptr, rr_ptr+1, … modulo N_REQ.
- Primary grant: the first valid requester in scan order.
- Secondary grant: the next valid requester in scan order whose rd differs from the primary grant's rd.
- Remaining requesters are not granted; req_ready=0 for them.
- hold=1: req_ready all 0, rr_ptr unchanged, and next-cycle regWrite=regWrite_c=0.
- No valid requesters: no grants, and both write enables go to 0 next cycle.
- Only one grant: it always goes to the primary port; regWrite_c=0 next cycle.
- rr_ptr update on any grant: (index of the last granted requester in scan order + 1) mod N_REQ. No grant: unchanged.
- Requester rule: valid must stay high with rd/data stable until ready. The arbiter does not buffer ungranted requests.
- Conflict event: the secondary port is unused and at least one valid requester was skipped only because its rd equals the primary rd.
  - Each such cycle increments conflict_cnt by 1.
  - The counter saturates at 16'hFFFF.
  - hold=1 cycles never count.
- rd/writeData of a port with write enable 0 hold their previous values, which are don't-care to consumers.

## Timing
- req_ready is a combinational function of req_valid, req_rd, hold and rr_ptr in the same cycle. There is no combinational path from req_data.
- A request accepted at edge k appears on the write port outputs after edge k. The register file captures it at edge k+1.
- Throughput: up to 2 writes per cycle with no bubbles between back-to-back grants.
- Reset (asynchronous, immediate):
  - rr_ptr=0, conflict_cnt=0.
  - regWrite=regWrite_c=0, rd=rd_c=0, writeData=writeData_c=0.
  - req_ready follows the combinational rule, using rr_ptr=0, while reset is high. Transfers during reset are discarded by the requester's own reset.
- Reset mid-stream: registered writes not yet captured by the register file are dropped. No partial-write state survives.
- Wrap-around: with N_REQ=3, rr_ptr=2 and grants to 2 then 0, rr_ptr becomes 1.

## Test plan
1. Reset check:
   - Stimulus: reset=1 with all req_valid=1.
   - Response: outputs all 0 immediately; after release, rr_ptr=0, so the first grants are req0 to primary and req1 to secondary.
2. Round-robin fairness:
   - Stimulus: all 3 valid with rd=1,2,3 continuously for 3 cycles.
   - Response: grant pairs are (0,1), (2,0), (1,2); primary/secondary rd follow the same order; conflict_cnt stays 0.
3. Same-destination conflict:
   - Stimulus: req0 rd=5 data=32'hAC0AC0AC and req1 rd=5 data=32'h12345678, rr_ptr=0.
   - Response:
     - Cycle 1: only req0 granted; rd=5, writeData=32'hAC0AC0AC, regWrite_c=0; conflict_cnt=1.
     - Cycle 2: req1 granted to primary with data 32'h12345678.
4. Hold:
   - Stimulus: hold=1 for 2 cycles with req2 valid (rd=7).
   - Response: req_ready=0 and regWrite=regWrite_c=0 for those cycles; rr_ptr unchanged; req2 is granted the cycle after hold drops.
5. Single requester:
   - Stimulus: only req1 valid, rd=15, data=32'hABABDEDE.
   - Response: primary rd=15, writeData=32'hABABDEDE after the edge, regWrite_c=0, rr_ptr=2.
6. Saturation and async reset:
   - Stimulus: force 65537 conflict cycles, then assert reset between clock edges.
   - Response: conflict_cnt holds 16'hFFFF, then clears to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: grants up to two pending results per cycle in round-robin order
// onto the primary and secondary register-file write ports, never both to the same rd.
module wb_port_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_rd,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      regWrite,
    output logic [ADDR_W-1:0]         rd,
    output logic [DATA_W-1:0]         writeData,
    output logic                      regWrite_c,
    output logic [ADDR_W-1:0]         rd_c,
    output logic [DATA_W-1:0]         writeData_c,
    output logic [15:0]               conflict_cnt
);

    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam logic [SUM_W-1:0] N_WRAP = SUM_W'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    logic [ADDR_W-1:0] w_rd   [N_REQ];
    logic [DATA_W-1:0] w_data [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_rd[g]   = req_rd[g*ADDR_W +: ADDR_W];
        assign w_data[g] = req_data[g*DATA_W +: DATA_W];
    end

    logic [PTR_W-1:0]  r_rr_ptr;
    logic              r_regWrite, r_regWrite_c;
    logic [ADDR_W-1:0] r_rd, r_rd_c;
    logic [DATA_W-1:0] r_writeData, r_writeData_c;
    logic [15:0]       r_conflict_cnt;

    logic [SUM_W-1:0]  w_sum;
    logic [PTR_W-1:0]  w_idx, w_pri_idx, w_sec_idx, w_last_idx, w_next_ptr;
    logic              w_pri_found, w_sec_found, w_same_skip, w_conflict;
    logic [N_REQ-1:0]  w_ready;

    // Walk requesters in scan order from r_rr_ptr; the secondary grant is the first
    // later valid requester whose rd differs from the primary's.
    always_comb begin
        w_sum       = '0;
        w_idx       = '0;
        w_pri_idx   = '0;
        w_sec_idx   = '0;
        w_pri_found = 1'b0;
        w_sec_found = 1'b0;
        w_same_skip = 1'b0;
        w_ready     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
            if (w_sum >= N_WRAP)
                w_sum = w_sum - N_WRAP;
            w_idx = w_sum[PTR_W-1:0];
            if (!hold && req_valid[w_idx]) begin
                if (!w_pri_found) begin
                    w_pri_found    = 1'b1;
                    w_pri_idx      = w_idx;
                    w_ready[w_idx] = 1'b1;
                end else if (!w_sec_found) begin
                    if (w_rd[w_idx] != w_rd[w_pri_idx]) begin
                        w_sec_found    = 1'b1;
                        w_sec_idx      = w_idx;
                        w_ready[w_idx] = 1'b1;
                    end else begin
                        w_same_skip = 1'b1;
                    end
                end
            end
        end
        w_last_idx = w_sec_found ? w_sec_idx : w_pri_idx;
        w_next_ptr = (w_last_idx == LAST_IDX) ? '0 : w_last_idx + PTR_W'(1);
        w_conflict = w_pri_found && !w_sec_found && w_same_skip;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr       <= '0;
            r_regWrite     <= 1'b0;
            r_regWrite_c   <= 1'b0;
            r_rd           <= '0;
            r_rd_c         <= '0;
            r_writeData    <= '0;
            r_writeData_c  <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_regWrite   <= w_pri_found;
            r_regWrite_c <= w_sec_found;
            if (w_pri_found) begin
                r_rr_ptr    <= w_next_ptr;
                r_rd        <= w_rd[w_pri_idx];
                r_writeData <= w_data[w_pri_idx];
            end
            if (w_sec_found) begin
                r_rd_c        <= w_rd[w_sec_idx];
                r_writeData_c <= w_data[w_sec_idx];
            end
            if (w_conflict && r_conflict_cnt != '1)
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign req_ready    = w_ready;
    assign regWrite     = r_regWrite;
    assign rd           = r_rd;
    assign writeData    = r_writeData;
    assign regWrite_c   = r_regWrite_c;
    assign rd_c         = r_rd_c;
    assign writeData_c  = r_writeData_c;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the grant rules.
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_rd;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            regWrite, regWrite_c;
    logic [AW-1:0]   rd, rd_c;
    logic [DW-1:0]   writeData, writeData_c;
    logic [15:0]     conflict_cnt;

    wb_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready),
        .regWrite(regWrite), .rd(rd), .writeData(writeData),
        .regWrite_c(regWrite_c), .rd_c(rd_c), .writeData_c(writeData_c),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int          m_ptr;
    logic        m_we, m_we_c;
    logic [AW-1:0] m_rd, m_rd_c;
    logic [DW-1:0] m_wd, m_wd_c;
    int          m_cnt;
    logic [N-1:0] last_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] rd_of(input int i);
        return req_rd[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return req_data[i*DW +: DW];
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we = 0; m_we_c = 0; m_rd = '0; m_rd_c = '0;
        m_wd = '0; m_wd_c = '0; m_cnt = 0;
    endtask

    task automatic model_grants(output logic [N-1:0] rdy, output int pri, output int sec,
                                output bit conf);
        int q[$];
        rdy = '0; pri = -1; sec = -1; conf = 0;
        if (hold) return;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) q.push_back(i);
        end
        if (q.size() == 0) return;
        pri = q[0];
        for (int j = 1; j < q.size(); j++) begin
            if (rd_of(q[j]) != rd_of(pri)) begin
                sec = q[j];
                break;
            end
        end
        // Unused secondary with other valid requesters means all of them share pri's rd
        conf = (sec < 0) && (q.size() > 1);
        rdy[pri] = 1'b1;
        if (sec >= 0) rdy[sec] = 1'b1;
    endtask

    // Inputs are driven just after a rising edge; this checks ready, clocks, checks outputs.
    task automatic cycle();
        logic [N-1:0] rdy;
        int pri, sec;
        bit conf;
        #1;
        model_grants(rdy, pri, sec, conf);
        chk("req_ready", 32'(req_ready), 32'(rdy));
        last_ready = rdy;
        @(posedge clk);
        #1;
        m_we   = (pri >= 0);
        m_we_c = (sec >= 0);
        if (pri >= 0) begin
            m_rd = rd_of(pri); m_wd = data_of(pri);
            m_ptr = (((sec >= 0) ? sec : pri) + 1) % N;
        end
        if (sec >= 0) begin
            m_rd_c = rd_of(sec); m_wd_c = data_of(sec);
        end
        if (conf && m_cnt < 16'hFFFF) m_cnt++;
        chk("regWrite", 32'(regWrite), 32'(m_we));
        chk("regWrite_c", 32'(regWrite_c), 32'(m_we_c));
        if (m_we) begin
            chk("rd", 32'(rd), 32'(m_rd));
            chk("writeData", writeData, m_wd);
        end
        if (m_we_c) begin
            chk("rd_c", 32'(rd_c), 32'(m_rd_c));
            chk("writeData_c", writeData_c, m_wd_c);
        end
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] r,
                           input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_rd[i*AW +: AW]  = r;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_we"}, 32'({regWrite, regWrite_c}), 32'd0);
        chk({tag, "_rd"}, 32'({rd, rd_c}), 32'd0);
        chk({tag, "_wd"}, writeData | writeData_c, 32'd0);
        chk({tag, "_cnt"}, 32'(conflict_cnt), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0;
        req_valid = '0; req_rd = '0; req_data = '0;
        model_reset();

        // Reset with all requesters valid
        set_req(0, 1, 4'd1, 32'h1111_0000);
        set_req(1, 1, 4'd2, 32'h2222_0000);
        set_req(2, 1, 4'd3, 32'h3333_0000);
        #2;
        check_outputs_zero("rst");
        chk("rst_ready", 32'(req_ready), 32'b011);
        @(posedge clk); #1;
        check_outputs_zero("rst_held");
        reset = 1'b0;

        // Round-robin: (0,1), (2,0), (1,2)
        cycle(); chk("rr1", 32'(last_ready), 32'b011);
        cycle(); chk("rr2", 32'(last_ready), 32'b101);
        chk("rr2_rd", 32'({rd, rd_c}), 32'h31);
        cycle(); chk("rr3", 32'(last_ready), 32'b110);

        // Same-destination conflict from rr_ptr=0
        do_reset();
        set_req(0, 1, 4'd5, 32'hAC0AC0AC);
        set_req(1, 1, 4'd5, 32'h12345678);
        set_req(2, 0, 4'd0, 32'h0);
        cycle();
        chk("conf_data", writeData, 32'hAC0AC0AC);
        chk("conf_cnt", 32'(conflict_cnt), 32'd1);
        req_valid[0] = 1'b0;
        cycle();
        chk("conf_data2", writeData, 32'h12345678);

        // Hold for 2 cycles, then req2 granted
        req_valid = '0;
        set_req(2, 1, 4'd7, 32'h7777_7777);
        hold = 1'b1;
        cycle(); cycle();
        hold = 1'b0;
        cycle();
        chk("hold_grant", 32'(last_ready), 32'b100);

        // Single requester: req1 only, then rr_ptr=2 visible in next scan
        do_reset();
        req_valid = '0;
        set_req(1, 1, 4'd15, 32'hABABDEDE);
        cycle();
        chk("single_data", writeData, 32'hABABDEDE);
        set_req(0, 1, 4'd1, 32'h0A);
        set_req(2, 1, 4'd3, 32'h0C);
        cycle();
        chk("single_next", 32'(last_ready), 32'b101);

        // Randomized traffic
        do_reset();
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            hold = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_ready[i]) begin
                    if ($urandom_range(0, 9) < 7)
                        set_req(i, 1, 4'($urandom_range(0, 3)), $urandom);
                    else
                        req_valid[i] = 1'b0;
                end
            end
            cycle();
        end

        // Saturation and asynchronous reset between edges
        do_reset();
        hold = 1'b0;
        set_req(0, 1, 4'd5, 32'h5);
        set_req(1, 1, 4'd5, 32'h6);
        set_req(2, 0, 4'd0, 32'h0);
        repeat (65537) @(posedge clk);
        #1;
        chk("sat_cnt", 32'(conflict_cnt), 32'h0000FFFF);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
